// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter driving the registered common data bus.
//
// Each functional-unit wrapper raises its req bit and presents a
// {tag, rs_onehot, value} word on its slice of fu_out. One requester wins
// per cycle. Its word is broadcast on cdb with the on bit set, for exactly
// one cycle.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   req          per-slot request, bit i = slot i
//   fu_out       concatenated {tag, rs, value} words, slot i at [(i+1)*W-1 : i*W]
//   cdb          registered bus {on, tag, rs, value}
//   grant        registered one-hot winner, all-zero when on=0
//   bcast_cnt    saturating count of broadcasts since reset
//   conflict_cnt saturating count of cycles with two or more requesters
module cdb_arbiter #(
    parameter int N_FU   = 5,
    parameter int TAG_W  = 3,
    parameter int RS_W   = 3,
    parameter int DATA_W = 32,
    parameter int CDB_W  = 1 + TAG_W + RS_W + DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_FU-1:0]             req,
    input  logic [N_FU*(CDB_W-1)-1:0]   fu_out,
    output logic [CDB_W-1:0]            cdb,
    output logic [N_FU-1:0]             grant,
    output logic [CNT_W-1:0]            bcast_cnt,
    output logic [CNT_W-1:0]            conflict_cnt
);

    localparam int WORD_W = CDB_W - 1;
    localparam int PTR_W  = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  ptr_next;
    logic [WORD_W-1:0] win_word;
    logic              any_req;
    logic              found;
    logic              multi;
    int unsigned       idx;

    // Walk slots starting at ptr, wrapping modulo N_FU; first set bit wins.
    always_comb begin
        any_req = |req;
        found   = 1'b0;
        win     = '0;
        idx     = 0;
        for (int unsigned k = 0; k < N_FU; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_FU) idx = idx - N_FU;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        // Only the winner's slice is selected, so junk on idle slots never reaches cdb.
        win_word = fu_out[32'(win)*WORD_W +: WORD_W];
        ptr_next = (win == PTR_W'(N_FU - 1)) ? '0 : win + PTR_W'(1);
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi    = (req & (req - N_FU'(1))) != '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb          <= '0;
            grant        <= '0;
            bcast_cnt    <= '0;
            conflict_cnt <= '0;
            ptr          <= '0;
        end else begin
            if (any_req) begin
                cdb   <= {1'b1, win_word};
                grant <= N_FU'(1) << win;
                ptr   <= ptr_next;
                if (bcast_cnt != '1) bcast_cnt <= bcast_cnt + CNT_W'(1);
            end else begin
                cdb   <= '0;
                grant <= '0;
            end
            if (multi && conflict_cnt != '1) conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule
